button_event_arbiter: RTL and testbench

Serialises level changes from up to eight debounced button channels into a single stream of press/release events, one event per handshake. It sits between the per-button `Debounce` instances and the consumer logic, such as a mode FSM or display controller. That consumer then handles one event at a time instead of watching N levels. Arbitration between channels is round-robin. Events lost because a channel changed twice before being served are flagged per channel.

---
 rtl/button_event_arbiter.sv | 114 +++++++++++
 tb/tb_button_event_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - round-robin serialiser of debounced button edges into press/release events
module button_event_arbiter #(
  parameter int c_NUM_CHANNELS = 4,
  parameter int c_IDX_WIDTH    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [c_NUM_CHANNELS-1:0] i_levels,
  input  logic                      i_event_ready,
  output logic                      o_event_valid,
  output logic [c_IDX_WIDTH-1:0]    o_event_channel,
  output logic                      o_event_press,
  output logic [c_NUM_CHANNELS-1:0] o_overrun,
  input  logic                      i_overrun_clear
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t                    r_state;
  logic [c_NUM_CHANNELS-1:0] r_prev;
  logic [c_NUM_CHANNELS-1:0] r_pend;
  logic [c_NUM_CHANNELS-1:0] r_pol;
  logic [c_NUM_CHANNELS-1:0] r_overrun;
  logic [c_IDX_WIDTH-1:0]    r_last_grant;
  logic                      r_valid;
  logic [c_IDX_WIDTH-1:0]    r_channel;
  logic                      r_press;

  logic [c_NUM_CHANNELS-1:0] w_edge;
  logic [c_NUM_CHANNELS-1:0] w_grant;
  logic                      w_found;
  logic [c_IDX_WIDTH-1:0]    w_winner;
  logic                      w_win_pol;

  assign w_edge = i_levels ^ r_prev;

  // Winner is the pending channel closest after last_grant in circular order.
  always_comb begin
    int v_dist;
    int v_best;
    v_dist    = 0;
    v_best    = c_NUM_CHANNELS;
    w_found   = 1'b0;
    w_winner  = '0;
    w_win_pol = 1'b0;
    for (int i = 0; i < c_NUM_CHANNELS; i++) begin
      v_dist = i - int'(r_last_grant) - 1;
      if (v_dist < 0) v_dist = v_dist + c_NUM_CHANNELS;
      if (r_pend[i] && (v_dist < v_best)) begin
        v_best    = v_dist;
        w_found   = 1'b1;
        w_winner  = c_IDX_WIDTH'(i);
        w_win_pol = r_pol[i];
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if ((r_state == S_IDLE) && w_found)
      w_grant = {{(c_NUM_CHANNELS-1){1'b0}}, 1'b1} << w_winner;
  end

  // A same-cycle edge on the granted channel re-arms pend without counting as lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_prev       <= i_levels;
      r_pend       <= '0;
      r_pol        <= '0;
      r_overrun    <= '0;
      r_last_grant <= c_IDX_WIDTH'(c_NUM_CHANNELS - 1);
      r_valid      <= 1'b0;
      r_channel    <= '0;
      r_press      <= 1'b0;
    end else begin
      r_prev    <= i_levels;
      r_pend    <= (r_pend & ~w_grant) | w_edge;
      r_pol     <= (r_pol & ~w_edge) | (i_levels & w_edge);
      r_overrun <= (r_overrun & {c_NUM_CHANNELS{~i_overrun_clear}})
                 | (w_edge & r_pend & ~w_grant);
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_channel    <= w_winner;
            r_press      <= w_win_pol;
            r_last_grant <= w_winner;
            r_valid      <= 1'b1;
            r_state      <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (i_event_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_event_valid   = r_valid;
  assign o_event_channel = r_channel;
  assign o_event_press   = r_press;
  assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - self-checking bench for button_event_arbiter
module tb_button_event_arbiter;
  localparam int N = 4;

  logic         clock;
  logic         reset;
  logic [N-1:0] i_levels;
  logic         i_event_ready;
  logic         o_event_valid;
  logic [1:0]   o_event_channel;
  logic         o_event_press;
  logic [N-1:0] o_overrun;
  logic         i_overrun_clear;

  int n_cmp = 0;
  int n_bad = 0;

  button_event_arbiter #(.c_NUM_CHANNELS(N), .c_IDX_WIDTH(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .i_levels       (i_levels),
    .i_event_ready  (i_event_ready),
    .o_event_valid  (o_event_valid),
    .o_event_channel(o_event_channel),
    .o_event_press  (o_event_press),
    .o_overrun      (o_overrun),
    .i_overrun_clear(i_overrun_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Event-level reference: each channel holds the level still waiting to be reported (-1 = none).
  int m_pl[N];
  int m_prev[N];
  int m_valid, m_chan, m_press, m_last;
  int m_ov[N];

  task automatic model_step();
    int g;
    int c;
    int lv;
    int clr_ov[N];
    g = -1;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_pl[i] = -1; m_prev[i] = int'(i_levels[i]); m_ov[i] = 0;
      end
      m_valid = 0; m_chan = 0; m_press = 0; m_last = N - 1;
    end else begin
      if (m_valid != 0) begin
        if (i_event_ready) m_valid = 0;
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (g < 0 && m_pl[c] >= 0) g = c;
        end
        if (g >= 0) begin
          m_chan = g; m_press = m_pl[g]; m_pl[g] = -1; m_last = g; m_valid = 1;
        end
      end
      for (int i = 0; i < N; i++) begin
        clr_ov[i] = i_overrun_clear ? 0 : m_ov[i];
        lv = int'(i_levels[i]);
        if (lv != m_prev[i]) begin
          if (m_pl[i] >= 0) clr_ov[i] = 1;
          m_pl[i] = lv;
        end
        m_prev[i] = lv;
        m_ov[i] = clr_ov[i];
      end
    end
  endtask

  function automatic int model_ov();
    int v;
    v = 0;
    for (int i = 0; i < N; i++) v = v | (m_ov[i] << i);
    return v;
  endfunction

  task automatic cycle(input logic rst, input logic [N-1:0] lv, input logic rdy, input logic clr);
    @(negedge clock);
    reset = rst; i_levels = lv; i_event_ready = rdy; i_overrun_clear = clr;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] lv;
    logic         rdy;
    logic         clr;
    logic         v;
    logic [1:0]   ch;
    logic         p;
    logic [N-1:0] ov;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [N-1:0] lv, input logic rdy, input logic clr,
                     input logic v, input logic [1:0] ch, input logic p, input logic [N-1:0] ov);
    vec_t e;
    e.rst = rst; e.lv = lv; e.rdy = rdy; e.clr = clr;
    e.v = v; e.ch = ch; e.p = p; e.ov = ov;
    tbl.push_back(e);
  endtask

  initial begin
    logic [N-1:0] lv;
    int grants[$];
    int exp_g[4];
    int prev_v;
    reset = 1'b1; i_levels = '0; i_event_ready = 1'b1; i_overrun_clear = 1'b0;

    // single press/release of channel 2
    add(0, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
    add(0, 4'b0100, 1, 0, 0, 0, 0, 4'b0000);
    add(0, 4'b0100, 1, 0, 1, 2, 1, 4'b0000);
    add(0, 4'b0100, 1, 0, 0, 2, 1, 4'b0000);
    add(0, 4'b0000, 1, 0, 0, 2, 1, 4'b0000);
    add(0, 4'b0000, 1, 0, 1, 2, 0, 4'b0000);
    add(0, 4'b0000, 1, 0, 0, 2, 0, 4'b0000);
    // simultaneous presses from reset priority
    add(1, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
    add(0, 4'b1111, 1, 0, 0, 0, 0, 4'b0000);
    add(0, 4'b1111, 1, 0, 1, 0, 1, 4'b0000);
    add(0, 4'b1111, 1, 0, 0, 0, 1, 4'b0000);
    add(0, 4'b1111, 1, 0, 1, 1, 1, 4'b0000);
    add(0, 4'b1111, 1, 0, 0, 1, 1, 4'b0000);
    add(0, 4'b1111, 1, 0, 1, 2, 1, 4'b0000);
    add(0, 4'b1111, 1, 0, 0, 2, 1, 4'b0000);
    add(0, 4'b1111, 1, 0, 1, 3, 1, 4'b0000);
    add(0, 4'b1111, 1, 0, 0, 3, 1, 4'b0000);
    add(0, 4'b1111, 1, 0, 0, 3, 1, 4'b0000);
    // backpressure with channel 1 overrun
    add(0, 4'b1110, 0, 0, 0, 3, 1, 4'b0000);
    add(0, 4'b1110, 0, 0, 1, 0, 0, 4'b0000);
    add(0, 4'b1100, 0, 0, 1, 0, 0, 4'b0000);
    add(0, 4'b1110, 0, 0, 1, 0, 0, 4'b0010);
    add(0, 4'b1100, 0, 0, 1, 0, 0, 4'b0010);
    add(0, 4'b1100, 1, 0, 0, 0, 0, 4'b0010);
    add(0, 4'b1100, 1, 0, 1, 1, 0, 4'b0010);
    add(0, 4'b1100, 1, 0, 0, 1, 0, 4'b0010);
    // edge on the granted channel, then set-wins-over-clear, then clear
    add(0, 4'b1110, 0, 0, 0, 1, 0, 4'b0010);
    add(0, 4'b1100, 0, 0, 1, 1, 1, 4'b0010);
    add(0, 4'b1110, 0, 1, 1, 1, 1, 4'b0010);
    add(0, 4'b1110, 0, 1, 1, 1, 1, 4'b0000);
    add(0, 4'b1110, 1, 0, 0, 1, 1, 4'b0000);
    add(0, 4'b1110, 1, 0, 1, 1, 1, 4'b0000);
    add(0, 4'b1110, 1, 0, 0, 1, 1, 4'b0000);
    // reset while presenting, and levels high through reset
    add(0, 4'b1010, 0, 0, 0, 1, 1, 4'b0000);
    add(0, 4'b1010, 0, 0, 1, 2, 0, 4'b0000);
    add(1, 4'b1010, 0, 0, 0, 0, 0, 4'b0000);
    add(0, 4'b1010, 1, 0, 0, 0, 0, 4'b0000);
    add(0, 4'b1010, 1, 0, 0, 0, 0, 4'b0000);
    add(1, 4'b0101, 1, 0, 0, 0, 0, 4'b0000);
    add(0, 4'b0101, 1, 0, 0, 0, 0, 4'b0000);
    add(0, 4'b0101, 1, 0, 0, 0, 0, 4'b0000);

    cycle(1, 4'b0000, 1, 0);
    cycle(1, 4'b0000, 1, 0);
    for (int t = 0; t < tbl.size(); t++) begin
      cycle(tbl[t].rst, tbl[t].lv, tbl[t].rdy, tbl[t].clr);
      check($sformatf("vec%0d valid", t), int'(o_event_valid), int'(tbl[t].v));
      check($sformatf("vec%0d channel", t), int'(o_event_channel), int'(tbl[t].ch));
      check($sformatf("vec%0d press", t), int'(o_event_press), int'(tbl[t].p));
      check($sformatf("vec%0d overrun", t), int'(o_overrun), int'(tbl[t].ov));
    end

    // round-robin fairness: after a channel-1 grant, channels 0 and 3 keep toggling
    cycle(1, 4'b0000, 1, 0);
    cycle(0, 4'b0010, 1, 0);
    cycle(0, 4'b0010, 1, 0);
    check("rr ch1 grant", int'(o_event_channel), 1);
    cycle(0, 4'b0010, 1, 0);
    lv = 4'b0010;
    prev_v = 0;
    exp_g = '{3, 0, 3, 0};
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      lv = lv ^ 4'b1001;
      cycle(0, lv, 1, 0);
      if (o_event_valid && prev_v == 0) grants.push_back(int'(o_event_channel));
      prev_v = int'(o_event_valid);
    end
    check("rr grant count", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      check($sformatf("rr grant%0d", k), grants[k], exp_g[k]);

    // randomized traffic against the reference model
    cycle(1, 4'b0000, 1, 0);
    lv = '0;
    for (int c = 0; c < 3000; c++) begin
      logic rst, rdy, clr;
      logic [N-1:0] flip;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 5) == 0);
      lv  = lv ^ flip;
      rst = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 15) == 0);
      cycle(rst, lv, rdy, clr);
      check($sformatf("rand%0d valid", c), int'(o_event_valid), m_valid);
      check($sformatf("rand%0d overrun", c), int'(o_overrun), model_ov());
      if (m_valid != 0) begin
        check($sformatf("rand%0d channel", c), int'(o_event_channel), m_chan);
        check($sformatf("rand%0d press", c), int'(o_event_press), m_press);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
